// File: rtl/alu64.sv
// ---------------------------------------------------------------------------
// alu64 - integer ALU of the EX stage.
//
// Computes ADD/SUB/AND/OR/XOR/SLL/SRA/SLT on A and B. It drives the result
// and the N/Z/C/V status flags combinationally. It also captures
// {Negative,Zero,Carry,Overflow} into flags_q on every rising clock edge.
//
// Optional feature macro: ALU_OUTREG_EN
//   When defined, ALU_Out and the four flag outputs are registered.
//   They then have one cycle of latency and clear while rst is low.
//   flags_q then lags the inputs by two edges.
//   When undefined, the result path is purely combinational.
//
// rst is asynchronous and active-low.
// ---------------------------------------------------------------------------
module alu64 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALU_Sel,
    output logic [WIDTH-1:0] ALU_Out,
    output logic             Zero,
    output logic             Negative,
    output logic             Carry,
    output logic             Overflow,
    output logic [3:0]       flags_q
);

    // Shift-amount width follows WIDTH and cannot be overridden.
    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_SRA = 3'b110,
        OP_SLT = 3'b111
    } alu_op_e;

    alu_op_e          op;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   add_sum;    // carry in bit WIDTH
    logic [WIDTH:0]   sub_sum;    // A + ~B + 1, no-borrow in bit WIDTH
    logic             add_ovf;
    logic             sub_ovf;
    logic             slt_bit;
    logic [WIDTH-1:0] res_c;
    logic             zero_c;
    logic             neg_c;
    logic             carry_c;
    logic             ovf_c;

    assign op    = alu_op_e'(ALU_Sel);
    // Only the low SHW bits of B select the shift distance, so a shift by WIDTH wraps to 0.
    assign shamt = B[SHW-1:0];

    // Shared adders: one for ADD and one for SUB.
    // The subtractor also feeds SLT, so the compare stays correct when A-B overflows.
    always_comb begin
        add_sum = {1'b0, A} + {1'b0, B};
        sub_sum = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
        // Signed overflow occurs when the operand signs (B inverted for SUB)
        // agree with each other but disagree with the result sign.
        add_ovf = (A[MSB] == B[MSB]) && (add_sum[MSB] != A[MSB]);
        sub_ovf = (A[MSB] != B[MSB]) && (sub_sum[MSB] != A[MSB]);
        // True signed less-than is N xor V of A-B.
        slt_bit = sub_sum[MSB] ^ sub_ovf;
    end

    // Result and flag selection from the decoded operation.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves
        // a variable unassigned and no latch is inferred.
        res_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        unique case (op)
            OP_ADD: begin
                res_c   = add_sum[WIDTH-1:0];
                carry_c = add_sum[WIDTH];
                ovf_c   = add_ovf;
            end
            OP_SUB: begin
                res_c   = sub_sum[WIDTH-1:0];
                carry_c = sub_sum[WIDTH];
                ovf_c   = sub_ovf;
            end
            OP_AND: res_c = A & B;
            OP_OR:  res_c = A | B;
            OP_XOR: res_c = A ^ B;
            OP_SLL: res_c = A << shamt;
            OP_SRA: res_c = WIDTH'($signed(A) >>> shamt);
            OP_SLT: res_c = {{(WIDTH-1){1'b0}}, slt_bit};
        endcase
        zero_c = (res_c == '0);
        neg_c  = res_c[MSB];
    end

`ifdef ALU_OUTREG_EN
    // Output register stage: the outputs show the inputs seen at the previous edge
    // and are cleared while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments. All registers then
        // update together from the values present before the edge.
        if (!rst) begin
            ALU_Out  <= '0;
            Zero     <= 1'b0;
            Negative <= 1'b0;
            Carry    <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            ALU_Out  <= res_c;
            Zero     <= zero_c;
            Negative <= neg_c;
            Carry    <= carry_c;
            Overflow <= ovf_c;
        end
    end
`else
    // Purely combinational result path. Reset does not affect it.
    always_comb begin
        ALU_Out  = res_c;
        Zero     = zero_c;
        Negative = neg_c;
        Carry    = carry_c;
        Overflow = ovf_c;
    end
`endif

    // Flag snapshot taken from the visible outputs on every rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) flags_q <= 4'b0000;
        else      flags_q <= {Negative, Zero, Carry, Overflow};
    end

endmodule

// File: tb/tb_alu64.sv
// ---------------------------------------------------------------------------
// tb_alu64 - self-checking bench for alu64.
//
// Table vectors with hand-derived results are applied, followed by random
// vectors scored by an independent model. Each expected record is pushed to a
// queue when its stimulus is driven. The record is popped when the DUT output
// is sampled one edge later. Sampling after an edge keeps the checks valid with
// or without ALU_OUTREG_EN.
// ---------------------------------------------------------------------------
module tb_alu64;

    localparam int W = 64;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] out;
        logic [3:0]   flags;  // {N,Z,C,V}
    } vec_t;

    typedef struct {
        logic [W-1:0] out;
        logic [3:0]   flags;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic [2:0]   sel = 3'b000;
    logic [W-1:0] alu_out;
    logic         zero, negative, carry, overflow;
    logic [3:0]   flags_q;

    int total = 0;
    int bad   = 0;

    vec_t vecs[$];
    exp_t sb[$];

    alu64 #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .A        (a_in),
        .B        (b_in),
        .ALU_Sel  (sel),
        .ALU_Out  (alu_out),
        .Zero     (zero),
        .Negative (negative),
        .Carry    (carry),
        .Overflow (overflow),
        .flags_q  (flags_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Independent reference model, built on widened signed arithmetic.
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t             e;
        logic [W:0]       w;
        logic signed [W:0] s;
        logic             c, v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: begin
                w = {1'b0, a} + {1'b0, b};
                e.out = w[W-1:0];
                c = w[W];
                s = $signed({a[W-1], a}) + $signed({b[W-1], b});
                v = s[W] != s[W-1];
            end
            3'd1: begin
                e.out = a - b;
                c = (a >= b);
                s = $signed({a[W-1], a}) - $signed({b[W-1], b});
                v = s[W] != s[W-1];
            end
            3'd2: e.out = a & b;
            3'd3: e.out = a | b;
            3'd4: e.out = a ^ b;
            3'd5: e.out = a << b[5:0];
            3'd6: e.out = W'($signed(a) >>> b[5:0]);
            default: e.out = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
        endcase
        e.flags = {e.out[W-1], e.out == '0, c, v};
        return e;
    endfunction

    // Drive one vector at a falling edge, then push its expected record.
    task automatic apply(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] out, input logic [3:0] flags);
        exp_t e;
        @(negedge clk);
        sel  = op;
        a_in = a;
        b_in = b;
        e.out   = out;
        e.flags = flags;
        sb.push_back(e);
    endtask

    // Pop the expected record and compare outputs, then flags_q one edge later.
    task automatic sample(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s sb_empty: got 0 want 1", tag);
            return;
        end
        e = sb.pop_front();
        check({tag, " out"}, alu_out, e.out);
        check({tag, " flags"}, W'({negative, zero, carry, overflow}), W'(e.flags));
        @(posedge clk);
        #1;
        check({tag, " flags_q"}, W'(flags_q), W'(e.flags));
    endtask

    initial begin
        exp_t m;
        logic [2:0]   rop;
        logic [W-1:0] ra, rb;

        // Hand-derived vectors: op, A, B, result, {N,Z,C,V}.
        vecs.push_back('{3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b1001});
        vecs.push_back('{3'd1, 64'd5, 64'd5, 64'd0, 4'b0110});
        vecs.push_back('{3'd7, 64'h8000_0000_0000_0000, 64'd1, 64'd1, 4'b0000});
        vecs.push_back('{3'd7, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 4'b0100});
        vecs.push_back('{3'd6, 64'hF000_0000_0000_0000, 64'd4, 64'hFF00_0000_0000_0000, 4'b1000});
        vecs.push_back('{3'd5, 64'd1, 64'h41, 64'd2, 4'b0000});
        vecs.push_back('{3'd2, 64'hF0F0, 64'h0FF0, 64'h00F0, 4'b0000});
        vecs.push_back('{3'd3, 64'hF0F0, 64'h0FF0, 64'hFFF0, 4'b0000});
        vecs.push_back('{3'd4, 64'hF0F0, 64'h0FF0, 64'hFF00, 4'b0000});
        vecs.push_back('{3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b0110});
        vecs.push_back('{3'd1, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000});
        vecs.push_back('{3'd1, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011});
        vecs.push_back('{3'd5, 64'd1, 64'h40, 64'd1, 4'b0000});
        vecs.push_back('{3'd6, 64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000});
        vecs.push_back('{3'd7, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd0, 4'b0100});
        vecs.push_back('{3'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0000});

        // Reset state: flags_q is clear while rst is low, even across edges.
        repeat (2) @(posedge clk);
        #1;
        check("reset flags_q", W'(flags_q), W'(0));
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].out, vecs[i].flags);
            sample($sformatf("vec%0d", i));
        end

        // Random vectors, scored by the model; a few use large shift amounts.
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = {$urandom, $urandom};
            rb  = (i % 5 == 0) ? W'($urandom_range(0, 255)) : {$urandom, $urandom};
            m   = model(rop, ra, rb);
            apply(rop, ra, rb, m.out, m.flags);
            sample($sformatf("rnd%0d", i));
        end

        // Mid-run async reset with flags_q = 1001.
        apply(3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b1001);
        sample("pre_rst");
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async rst flags_q", W'(flags_q), W'(0));
`ifdef ALU_OUTREG_EN
        check("async rst out", alu_out, W'(0));
`else
        check("async rst out", alu_out, 64'h8000_0000_0000_0000);
`endif
        @(posedge clk);
        #1;
        check("rst held flags_q", W'(flags_q), W'(0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst out", alu_out, 64'h8000_0000_0000_0000);
`ifdef ALU_OUTREG_EN
        check("post_rst flags_q e1", W'(flags_q), W'(0));
        @(posedge clk);
        #1;
`endif
        check("post_rst flags_q", W'(flags_q), W'(4'b1001));

        check("sb drained", W'(sb.size()), W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
